nand_chan_model: RTL and testbench

NAND_CHAN_MODEL -- requirements
Module: nand_chan_model

---
 rtl/nand_chan_pkg.sv | 43 ++++
 rtl/nand_die_fsm.sv | 143 ++++++++++++++
 rtl/nand_chan_model.sv | 88 ++++++++
 tb/tb_nand_chan_model.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/nand_chan_pkg.sv
// Shared opcodes, die FSM state encoding, address-count targets and the
// per-die write request passed from the channel strobe logic to each die.
package nand_chan_pkg;

  localparam logic [7:0] OP_READ      = 8'h00;
  localparam logic [7:0] OP_READ_CFM  = 8'h30;
  localparam logic [7:0] OP_PROG      = 8'h80;
  localparam logic [7:0] OP_PROG_CFM  = 8'h10;
  localparam logic [7:0] OP_ERASE     = 8'h60;
  localparam logic [7:0] OP_ERASE_CFM = 8'hD0;
  localparam logic [7:0] OP_STATUS    = 8'h70;
  localparam logic [7:0] OP_RESET     = 8'hFF;

  localparam int         ACNT_W       = 3;
  localparam logic [2:0] ACNT_READ    = 3'd5;
  localparam logic [2:0] ACNT_PROG    = 3'd5;
  localparam logic [2:0] ACNT_ERASE   = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ADDR = 2'd2,
    ST_BUSY = 2'd3
  } die_st_e;

  // One latched write cycle as seen by one die (already gated by its CEN).
  typedef struct packed {
    logic       cmd;
    logic       addr;
    logic [7:0] data;
  } wr_req_t;

  // Largest of the four busy times; sizes the shared timer width.
  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/nand_die_fsm.sv
// Single NAND die: command/address sequencer, busy timer, status byte.
// Write-protect blocking of program/erase is compiled in only when
// NAND_CHAN_MODEL_WP_EN is defined.
module nand_die_fsm
  import nand_chan_pkg::*;
#(
  parameter int T_R    = 25,
  parameter int T_PROG = 200,
  parameter int T_BERS = 1000,
  parameter int T_RST  = 5,
  parameter int TMR_W  = 11
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  wr_req_t    req_i,
  input  logic       wp_lvl_i,
  output logic       rb_o,
  output logic       stat_mode_o,
  output logic [7:0] status_o
);

  die_st_e           state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic [7:0]        op_q, op_d;
  logic              stat_q, stat_d;
  logic              fail_q, fail_d;

  logic [7:0]        cfm_exp;
  logic [ACNT_W-1:0] acnt_tgt;
  logic [TMR_W-1:0]  tmr_load;
  logic              cfm_ok;
  logic              wp_block;

  // Per-opcode confirm byte, address target and busy time.
  always_comb begin
    cfm_exp  = OP_READ_CFM;
    acnt_tgt = ACNT_READ;
    tmr_load = TMR_W'(T_R);
    case (op_q)
      OP_PROG: begin
        cfm_exp  = OP_PROG_CFM;
        acnt_tgt = ACNT_PROG;
        tmr_load = TMR_W'(T_PROG);
      end
      OP_ERASE: begin
        cfm_exp  = OP_ERASE_CFM;
        acnt_tgt = ACNT_ERASE;
        tmr_load = TMR_W'(T_BERS);
      end
      default: ;
    endcase
  end

  assign cfm_ok = (state_q == ST_ADDR) && (req_i.data == cfm_exp) && (acnt_q == acnt_tgt);

`ifdef NAND_CHAN_MODEL_WP_EN
  assign wp_block = ~wp_lvl_i && (op_q != OP_READ);
`else
  assign wp_block = 1'b0;
`endif

  // State, timer and flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      acnt_q  <= '0;
      op_q    <= OP_READ;
      stat_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      acnt_q  <= acnt_d;
      op_q    <= op_d;
      stat_q  <= stat_d;
      fail_q  <= fail_d;
    end
  end

  // Next state: busy countdown first, then any write in this cycle overrides.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    acnt_d  = acnt_q;
    op_d    = op_q;
    stat_d  = stat_q;
    fail_d  = fail_q;

    if (state_q == ST_BUSY) begin
      if (tmr_q <= TMR_W'(1)) begin
        state_d = ST_IDLE;
        tmr_d   = '0;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end

    if (req_i.cmd) begin
      stat_d = (req_i.data == OP_STATUS);
      case (req_i.data)
        OP_RESET: begin
          state_d = ST_BUSY;
          tmr_d   = TMR_W'(T_RST);
          acnt_d  = '0;
        end
        OP_STATUS: ;
        OP_READ, OP_PROG, OP_ERASE: begin
          if (state_q == ST_IDLE || state_q == ST_CMD) begin
            state_d = ST_CMD;
            op_d    = req_i.data;
            acnt_d  = '0;
          end
        end
        OP_READ_CFM, OP_PROG_CFM, OP_ERASE_CFM: begin
          if (state_q != ST_BUSY) begin
            acnt_d = '0;
            if (cfm_ok && !wp_block) begin
              state_d = ST_BUSY;
              tmr_d   = tmr_load;
              fail_d  = 1'b0;
            end else begin
              state_d = ST_IDLE;
              if (cfm_ok) fail_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end else if (req_i.addr) begin
      if (state_q == ST_CMD || state_q == ST_ADDR) begin
        state_d = ST_ADDR;
        if (acnt_q < acnt_tgt) acnt_d = acnt_q + ACNT_W'(1);
      end
    end
  end

  assign rb_o        = (state_q != ST_BUSY);
  assign stat_mode_o = stat_q;
  assign status_o    = {wp_lvl_i, rb_o, rb_o, 4'b0000, fail_q};

endmodule

// File: rtl/nand_chan_model.sv
// NAND channel model: WRN strobe detect, per-die fan-out and status read mux.
// Define NAND_CHAN_MODEL_WP_EN to honour WPN for program/erase.
module nand_chan_model
  import nand_chan_pkg::*;
#(
  parameter int NUM_DIES = 8,
  parameter int T_R      = 25,
  parameter int T_PROG   = 200,
  parameter int T_BERS   = 1000,
  parameter int T_RST    = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [7:0]          DQ_I,
  output logic [7:0]          DQ_O,
  output logic                DQ_OE,
  input  logic                CLE,
  input  logic                ALE,
  input  logic [NUM_DIES-1:0] CEN,
  input  logic                WRN,
  input  logic                REN,
  input  logic                WPN,
  output logic [NUM_DIES-1:0] RB
);

  localparam int TMR_W = $clog2(max_of4(T_R, T_PROG, T_BERS, T_RST)) + 1;

  logic                     wrn_q;
  logic                     wr_cyc;
  logic                     wp_lvl;
  logic [NUM_DIES-1:0]      stat_mode;
  logic [NUM_DIES-1:0][7:0] status;
  logic                     oe_d;
  logic [7:0]               dq_d;

  // Delayed WRN for rising-edge detect of the write strobe.
  always_ff @(posedge CLK) begin
    if (RST) wrn_q <= 1'b1;
    else     wrn_q <= WRN;
  end

  assign wr_cyc = ~wrn_q & WRN;

`ifdef NAND_CHAN_MODEL_WP_EN
  assign wp_lvl = WPN;
`else
  assign wp_lvl = WPN | 1'b1;
`endif

  for (genvar g = 0; g < NUM_DIES; g++) begin : g_die
    wr_req_t req;
    assign req.cmd  = wr_cyc & ~CEN[g] & CLE & ~ALE;
    assign req.addr = wr_cyc & ~CEN[g] & ALE & ~CLE;
    assign req.data = DQ_I;

    nand_die_fsm #(
      .T_R    (T_R),
      .T_PROG (T_PROG),
      .T_BERS (T_BERS),
      .T_RST  (T_RST),
      .TMR_W  (TMR_W)
    ) u_die (
      .clk_i       (CLK),
      .rst_i       (RST),
      .req_i       (req),
      .wp_lvl_i    (wp_lvl),
      .rb_o        (RB[g]),
      .stat_mode_o (stat_mode[g]),
      .status_o    (status[g])
    );
  end

  // Status read mux: scanning high to low leaves the lowest selected die.
  always_comb begin
    oe_d = 1'b0;
    dq_d = 8'h00;
    for (int i = NUM_DIES - 1; i >= 0; i--) begin
      if (stat_mode[i] && !CEN[i]) begin
        oe_d = 1'b1;
        dq_d = status[i];
      end
    end
  end

  assign DQ_OE = oe_d & ~REN;
  assign DQ_O  = REN ? 8'h00 : dq_d;

endmodule

// File: tb/tb_nand_chan_model.sv
// Directed bench for nand_chan_model: single-write vector table plus
// hand-written busy-timing, status, reset and write-protect sequences.
module tb_nand_chan_model;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] DQ_I = 8'h00;
  logic [7:0] DQ_O;
  logic       DQ_OE;
  logic       CLE = 1'b0;
  logic       ALE = 1'b0;
  logic [7:0] CEN = 8'hFF;
  logic       WRN = 1'b1;
  logic       REN = 1'b0;
  logic       WPN = 1'b1;
  logic [7:0] RB;

  int total = 0;
  int bad   = 0;

  nand_chan_model dut (
    .CLK   (CLK),
    .RST   (RST),
    .DQ_I  (DQ_I),
    .DQ_O  (DQ_O),
    .DQ_OE (DQ_OE),
    .CLE   (CLE),
    .ALE   (ALE),
    .CEN   (CEN),
    .WRN   (WRN),
    .REN   (REN),
    .WPN   (WPN),
    .RB    (RB)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] cen;
    logic       cle;
    logic       ale;
    logic [7:0] dq;
    logic [7:0] rb;
    logic       oe;
    logic [7:0] dqo;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // One write cycle; returns at the falling edge after the latching edge.
  task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge CLK);
    CLE = cle; ALE = ale; DQ_I = d; WRN = 1'b0;
    @(negedge CLK);
    WRN = 1'b1;
    @(negedge CLK);
    CLE = 1'b0; ALE = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);
    wr(1'b1, 1'b0, d);
  endtask

  task automatic addr_n(input int n);
    for (int k = 0; k < n; k++) wr(1'b0, 1'b1, 8'(k + 1));
  endtask

  // Counts consecutive low cycles of RB[b]; others_hi reports RB bits other than b stayed high.
  task automatic count_low(input int b, input int bound, output int n, output logic others_hi);
    logic [7:0] mask;
    mask = 8'hFF;
    mask[b] = 1'b0;
    n = 0;
    others_hi = 1'b1;
    while (RB[b] == 1'b0 && n < bound) begin
      if ((RB & mask) != mask) others_hi = 1'b0;
      n++;
      @(negedge CLK);
    end
  endtask

  initial begin
    int   n;
    logic hi;

    tbl[0]  = '{8'hFE, 1'b1, 1'b0, 8'h70, 8'hFF, 1'b1, 8'hE0};
    tbl[1]  = '{8'hFE, 1'b1, 1'b0, 8'h60, 8'hFF, 1'b0, 8'h00};
    tbl[2]  = '{8'hFE, 1'b0, 1'b1, 8'h01, 8'hFF, 1'b0, 8'h00};
    tbl[3]  = '{8'hFE, 1'b0, 1'b1, 8'h02, 8'hFF, 1'b0, 8'h00};
    tbl[4]  = '{8'hFE, 1'b1, 1'b0, 8'hD0, 8'hFF, 1'b0, 8'h00};
    tbl[5]  = '{8'hFE, 1'b1, 1'b0, 8'h70, 8'hFF, 1'b1, 8'hE0};
    tbl[6]  = '{8'hFE, 1'b1, 1'b1, 8'h00, 8'hFF, 1'b1, 8'hE0};
    tbl[7]  = '{8'hFE, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'hE0};
    tbl[8]  = '{8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b0, 8'h00};
    tbl[9]  = '{8'hFD, 1'b1, 1'b0, 8'h70, 8'hFF, 1'b1, 8'hE0};
    tbl[10] = '{8'hFE, 1'b1, 1'b0, 8'h30, 8'hFF, 1'b0, 8'h00};

    do_reset();
    chk("reset_rb", RB, 8'hFF);
    chk("reset_oe", DQ_OE, 1'b0);
    chk("reset_dqo", DQ_O, 8'h00);

    for (int i = 0; i < 11; i++) begin
      CEN = tbl[i].cen;
      wr(tbl[i].cle, tbl[i].ale, tbl[i].dq);
      chk($sformatf("vec%0d_rb", i), RB, tbl[i].rb);
      chk($sformatf("vec%0d_oe", i), DQ_OE, tbl[i].oe);
      chk($sformatf("vec%0d_dqo", i), DQ_O, tbl[i].dqo);
    end

    // Read on die 0: exact busy length, other dies untouched.
    do_reset();
    CEN = 8'hFE;
    cmd(8'h00); addr_n(5); cmd(8'h30);
    chk("read_rb_fall", RB, 8'hFE);
    count_low(0, 100, n, hi);
    chk("read_busy_len", n, 25);
    chk("read_others_hi", hi, 1'b1);
    chk("read_rb_rise", RB, 8'hFF);

    // Full erase with a surplus address byte (count saturates at 3).
    cmd(8'h60); addr_n(4); cmd(8'hD0);
    count_low(0, 1100, n, hi);
    chk("erase_busy_len", n, 1000);

    // Program with status polling and lowest-die priority.
    cmd(8'h80); addr_n(5); cmd(8'h10);
    chk("prog_rb_fall", RB, 8'hFE);
    cmd(8'h70);
    chk("prog_stat_oe", DQ_OE, 1'b1);
    chk("prog_stat_busy", DQ_O, 8'h80);
    cmd(8'h00);
    chk("busy_cmd_ignored_rb", RB, 8'hFE);
    cmd(8'h70);
    CEN = 8'hFD;
    cmd(8'h70);
    CEN = 8'hFC;
    #1 chk("prio_die0", DQ_O, 8'h80);
    CEN = 8'hFD;
    #1 chk("die1_only", DQ_O, 8'hE0);
    CEN = 8'hFE;
    REN = 1'b1;
    #1 chk("ren_hi_oe", DQ_OE, 1'b0);
    REN = 1'b0;
    @(negedge CLK);
    count_low(0, 300, n, hi);
    chk("prog_rb_rise", RB, 8'hFF);
    chk("prog_stat_ready", DQ_O, 8'hE0);

    // Reset command 50 cycles into a program.
    cmd(8'h80); addr_n(5); cmd(8'h10);
    repeat (48) @(negedge CLK);
    cmd(8'hFF);
    count_low(0, 100, n, hi);
    chk("ffh_busy_len", n, 5);
    chk("ffh_rb_rise", RB, 8'hFF);
    chk("ffh_clears_stat", DQ_OE, 1'b0);

    // Program while write-protected.
    WPN = 1'b0;
    cmd(8'h80); addr_n(5); cmd(8'h10);
`ifdef NAND_CHAN_MODEL_WP_EN
    chk("wp_rb_high", RB, 8'hFF);
    cmd(8'h70);
    chk("wp_status", DQ_O, 8'h61);
`else
    chk("nowp_rb_fall", RB, 8'hFE);
    cmd(8'hFF);
    count_low(0, 100, n, hi);
    chk("nowp_ffh_len", n, 5);
    cmd(8'h70);
    chk("nowp_status", DQ_O, 8'hE0);
`endif
    WPN = 1'b1;

    // All dies read together, then a mid-busy synchronous reset.
    do_reset();
    CEN = 8'h00;
    cmd(8'h00); addr_n(5); cmd(8'h30);
    chk("all_rb_fall", RB, 8'h00);
    repeat (8) @(negedge CLK);
    chk("all_still_busy", RB, 8'h00);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_busy_rb", RB, 8'hFF);
    chk("rst_mid_busy_oe", DQ_OE, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_rb", RB, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
